imem_fetch_ctrl: RTL and testbench

- Fetch sequencer for the pipelined RV32I core's instruction memory, which is word-indexed with a combinational read.
- Owns the program counter and converts byte PC to a word index for the memory.
- Buffers fetched words in a 2-entry queue toward decode (valid/ready).
- Handles branch/jump redirects, boot delay, halt/resume and address faults.

---
 rtl/imem_fetch_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the byte PC, drives a word-indexed combinational
// instruction memory and buffers fetched words in a 2-entry queue toward decode.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          DEPTH       = 1024,
    parameter int          BOOT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rd_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        valid_o,
    input  logic        ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        halt_i,
    input  logic        resume_i,
    output logic        fault_o,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_HALT  = 2'b10,
        ST_FAULT = 2'b11
    } state_t;

    localparam logic [31:0] LAST_PC   = 32'(DEPTH * 4 - 4);
    localparam logic [31:0] BOOT_LAST = 32'(BOOT_CYCLES - 1);

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] boot_cnt_r, boot_cnt_s;
    logic [1:0]  cnt_r, cnt_s;
    logic [31:0] head_instr_r, head_instr_s;
    logic [31:0] head_pc_r, head_pc_s;
    logic [31:0] tail_instr_r, tail_instr_s;
    logic [31:0] tail_pc_r, tail_pc_s;
    logic        valid_r, valid_s;
    logic        fault_r, fault_s;
    logic        pop_s;
    logic        push_s;
    logic        flush_s;
    logic        fetch_ok_s;
    logic        redirect_bad_s;

    assign imem_addr_o = {2'b00, pc_r[31:2]};
    assign instr_o     = head_instr_r;
    assign pc_o        = head_pc_r;
    assign valid_o     = valid_r;
    assign fault_o     = fault_r;
    assign state_o     = state_r;

    // Next-state and PC sequencing; halt outranks redirect, redirect outranks fetch.
    always_comb begin
        state_s        = state_r;
        pc_s           = pc_r;
        boot_cnt_s     = boot_cnt_r;
        push_s         = 1'b0;
        flush_s        = 1'b0;
        pop_s          = valid_r && ready_i;
        fetch_ok_s     = (cnt_r < 2'd2) || pop_s;
        redirect_bad_s = (redirect_pc_i[1:0] != 2'b00) || (redirect_pc_i > LAST_PC);
        case (state_r)
            ST_BOOT: begin
                boot_cnt_s = boot_cnt_r + 32'd1;
                if (boot_cnt_r >= BOOT_LAST) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_BOOT;
                end
            end
            ST_RUN: begin
                if (halt_i) begin
                    state_s = ST_HALT;
                end else if (redirect_i) begin
                    flush_s = 1'b1;
                    if (redirect_bad_s) begin
                        state_s = ST_FAULT;
                    end else begin
                        pc_s = redirect_pc_i;
                    end
                end else if (fetch_ok_s) begin
                    // Sequential run-off past the last word is a fault, not a fetch.
                    if (pc_r > LAST_PC) begin
                        state_s = ST_FAULT;
                        flush_s = 1'b1;
                    end else begin
                        push_s = 1'b1;
                        pc_s   = pc_r + 32'd4;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_HALT: begin
                if (resume_i && !halt_i) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_HALT;
                end
            end
            ST_FAULT: begin
                flush_s = 1'b1;
            end
            default: begin
                state_s = ST_FAULT;
                flush_s = 1'b1;
            end
        endcase
    end

    // Queue bookkeeping; head registers keep their last contents when the queue empties.
    always_comb begin
        cnt_s        = cnt_r;
        head_instr_s = head_instr_r;
        head_pc_s    = head_pc_r;
        tail_instr_s = tail_instr_r;
        tail_pc_s    = tail_pc_r;
        if (flush_s) begin
            cnt_s = 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (cnt_r == 2'd0) begin
                        head_instr_s = imem_rd_i;
                        head_pc_s    = pc_r;
                        cnt_s        = 2'd1;
                    end else begin
                        tail_instr_s = imem_rd_i;
                        tail_pc_s    = pc_r;
                        cnt_s        = 2'd2;
                    end
                end
                2'b01: begin
                    if (cnt_r == 2'd2) begin
                        head_instr_s = tail_instr_r;
                        head_pc_s    = tail_pc_r;
                    end else begin
                        head_instr_s = head_instr_r;
                    end
                    cnt_s = cnt_r - 2'd1;
                end
                2'b11: begin
                    if (cnt_r == 2'd1) begin
                        head_instr_s = imem_rd_i;
                        head_pc_s    = pc_r;
                    end else begin
                        head_instr_s = tail_instr_r;
                        head_pc_s    = tail_pc_r;
                        tail_instr_s = imem_rd_i;
                        tail_pc_s    = pc_r;
                    end
                end
                default: begin
                    cnt_s = cnt_r;
                end
            endcase
        end
        valid_s = (cnt_s != 2'd0);
        fault_s = (state_s == ST_FAULT);
    end

    // State, PC and queue registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_BOOT;
            pc_r         <= RESET_PC;
            boot_cnt_r   <= 32'd0;
            cnt_r        <= 2'd0;
            head_instr_r <= 32'd0;
            head_pc_r    <= 32'd0;
            tail_instr_r <= 32'd0;
            tail_pc_r    <= 32'd0;
            valid_r      <= 1'b0;
            fault_r      <= 1'b0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            boot_cnt_r   <= boot_cnt_s;
            cnt_r        <= cnt_s;
            head_instr_r <= head_instr_s;
            head_pc_r    <= head_pc_s;
            tail_instr_r <= tail_instr_s;
            tail_pc_r    <= tail_pc_s;
            valid_r      <= valid_s;
            fault_r      <= fault_s;
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: a queue-based reference model predicts the
// instructions decode accepts; a separate monitor compares them as the DUT presents them.
module tb_imem_fetch_ctrl;

    localparam int          DEPTH = 1024;
    localparam int          AW    = 10;
    localparam int          BOOTC = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] LAST  = 32'(DEPTH * 4 - 4);
    localparam logic [1:0]  M_BOOT = 2'b00, M_RUN = 2'b01, M_HALT = 2'b10, M_FAULT = 2'b11;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr_o, imem_rd_i, instr_o, pc_o, redirect_pc_i;
    logic        valid_o, ready_i, redirect_i, halt_i, resume_i, fault_o;
    logic [1:0]  state_o;

    logic [31:0] mem [0:DEPTH-1];

    ent_t        mq[$];
    ent_t        sb[$];
    logic [1:0]  mstate;
    logic [31:0] mpc;
    int          mboot;
    logic        exp_valid, exp_fault;
    logic [1:0]  exp_state;
    logic [31:0] exp_addr;
    logic        chk_en = 1'b0;
    int          checks = 0;
    int          errors = 0;

    imem_fetch_ctrl #(.RESET_PC(RPC), .DEPTH(DEPTH), .BOOT_CYCLES(BOOTC)) dut (
        .clk(clk), .rst(rst), .imem_addr_o(imem_addr_o), .imem_rd_i(imem_rd_i),
        .instr_o(instr_o), .pc_o(pc_o), .valid_o(valid_o), .ready_i(ready_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .halt_i(halt_i),
        .resume_i(resume_i), .fault_o(fault_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    assign imem_rd_i = (imem_addr_o < 32'(DEPTH)) ? mem[imem_addr_o[AW-1:0]] : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares per-cycle status and every accepted instruction against the scoreboard.
    always @(negedge clk) begin
        if (chk_en) begin
            ent_t e;
            chk("valid_o", {31'd0, valid_o}, {31'd0, exp_valid});
            chk("state_o", {30'd0, state_o}, {30'd0, exp_state});
            chk("fault_o", {31'd0, fault_o}, {31'd0, exp_fault});
            chk("imem_addr_o", imem_addr_o, exp_addr);
            if (valid_o && ready_i) begin
                chk("pop_expected", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("instr_o", instr_o, e.instr);
                    chk("pc_o", pc_o, e.pc);
                end
            end
        end
    end

    task automatic model_init();
        mq.delete();
        sb.delete();
        mstate = M_BOOT;
        mpc    = RPC;
        mboot  = 0;
    endtask

    // Apply one cycle of inputs, publish this cycle's expectations, advance the model.
    task automatic step_in(input logic r, input logic rd, input logic [31:0] rpc,
                           input logic h, input logic rs);
        ent_t e;
        ready_i = r; redirect_i = rd; redirect_pc_i = rpc; halt_i = h; resume_i = rs;
        exp_valid = (mq.size() != 0);
        exp_state = mstate;
        exp_fault = (mstate == M_FAULT);
        exp_addr  = {2'b00, mpc[31:2]};
        if (mq.size() != 0 && r) begin
            e = mq.pop_front();
            sb.push_back(e);
        end
        case (mstate)
            M_BOOT: begin
                if (mboot == BOOTC - 1) mstate = M_RUN;
                mboot++;
            end
            M_RUN: begin
                if (h) begin
                    mstate = M_HALT;
                end else if (rd) begin
                    mq.delete();
                    if (rpc[1:0] != 2'b00 || rpc > LAST) mstate = M_FAULT;
                    else mpc = rpc;
                end else if (mq.size() < 2) begin
                    if (mpc > LAST) begin
                        mstate = M_FAULT;
                        mq.delete();
                    end else begin
                        e.instr = mem[mpc[AW+1:2]];
                        e.pc    = mpc;
                        mq.push_back(e);
                        mpc = mpc + 32'd4;
                    end
                end
            end
            M_HALT: if (rs && !h) mstate = M_RUN;
            default: ;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input logic r);
        for (int i = 0; i < n; i++) step_in(r, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst = 1'b1;
        ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0; halt_i = 1'b0; resume_i = 1'b0;
        model_init();
        @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_state", {30'd0, state_o}, 32'd0);
        chk("rst_fault", {31'd0, fault_o}, 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_addr", imem_addr_o, {2'b00, RPC[31:2]});
        rst = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic step_rand();
        logic [31:0] tgt;
        int sel;
        sel = int'($urandom_range(0, 63));
        if (sel == 0)     tgt = {24'd0, 6'($urandom), 2'($urandom_range(1, 3))};
        else if (sel == 1) tgt = LAST + 32'd4;
        else if (sel < 6)  tgt = LAST - 32'(4 * $urandom_range(0, 3));
        else               tgt = 32'(4 * $urandom_range(0, 63));
        step_in(($urandom % 4) != 0, ($urandom % 16) == 0, tgt,
                ($urandom % 20) == 0, ($urandom % 4) == 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        // Boot and streaming
        do_reset();
        run(8, 1'b1);
        // Backpressure then release
        do_reset();
        run(2, 1'b1);
        run(5, 1'b0);
        run(6, 1'b1);
        // Redirect with a full queue
        run(3, 1'b0);
        step_in(1'b0, 1'b1, 32'h10, 1'b0, 1'b0);
        run(5, 1'b1);
        // Halt with one entry queued, drain, resume; then halt with redirect
        do_reset();
        run(2, 1'b1);
        step_in(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        step_in(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        run(4, 1'b1);
        step_in(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
        step_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        run(4, 1'b1);
        step_in(1'b1, 1'b1, 32'h40, 1'b1, 1'b0);
        run(2, 1'b1);
        step_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        run(4, 1'b1);
        // Misaligned redirect, then out-of-range redirect; other inputs ignored afterwards
        do_reset();
        run(4, 1'b1);
        step_in(1'b1, 1'b1, 32'h6, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step_in(1'b1, i[0], 32'h20, i[1], 1'b1);
        do_reset();
        run(4, 1'b1);
        step_in(1'b0, 1'b1, 32'h1000, 1'b0, 1'b0);
        run(4, 1'b1);
        // Sequential run-off past the end of memory
        do_reset();
        run(3, 1'b1);
        step_in(1'b1, 1'b1, LAST - 32'd4, 1'b0, 1'b0);
        run(6, 1'b1);
        // Asynchronous reset mid-run with the queue occupied
        do_reset();
        run(3, 1'b1);
        run(3, 1'b0);
        #2;
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_valid", {31'd0, valid_o}, 32'd0);
        chk("async_state", {30'd0, state_o}, 32'd0);
        chk("async_fault", {31'd0, fault_o}, 32'd0);
        @(posedge clk);
        #1;
        // Randomized segments
        for (int s = 0; s < 12; s++) begin
            do_reset();
            for (int c = 0; c < 250; c++) step_rand();
        end
        chk_en = 1'b0;
        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
